// File: rtl/keyboard_spi_rx.sv
// keyboard_spi_rx: SPI mode-0 slave that receives KEY_WIDTH-bit key codes.
// The block runs entirely on sck. The key output holds the last complete
// code received. When cs_n is high, the shift register and bit counter are
// held cleared. The key register is cleared only by rst_n.
// Optional macro KEYBOARD_LSB_FIRST_EN: when defined, bits arrive LSB first.
// By default they arrive MSB first.
module keyboard_spi_rx #(
    parameter int KEY_WIDTH = 8
) (
    input  logic                 sck,
    input  logic                 rst_n,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic [KEY_WIDTH-1:0] key
);

    localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

    logic [KEY_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 last_bit;

    // Frame state is cleared by reset, or whenever chip select is idle.
    logic frame_clr_n;
    assign frame_clr_n = rst_n & ~cs_n;

    // Next-state: shift in mosi, count bits, latch the word on the final bit.
    always_comb begin
`ifdef KEYBOARD_LSB_FIRST_EN
        shift_d = {mosi, shift_q[KEY_WIDTH-1:1]};
`else
        shift_d = {shift_q[KEY_WIDTH-2:0], mosi};
`endif
        last_bit = (cnt_q == CW'(KEY_WIDTH - 1));
        cnt_d    = last_bit ? '0 : cnt_q + CW'(1);
        key_d    = key_q;
        // shift_d already contains the completed word on the last bit, so key
        // updates on that same edge with no extra latency.
        if (last_bit && !cs_n)
            key_d = shift_d;
    end

    // Shift register and bit counter; async-cleared by reset or idle cs_n.
    always_ff @(posedge sck or negedge frame_clr_n) begin
        if (!frame_clr_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Key register; only reset clears it, so the code survives between frames.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n)
            key_q <= '0;
        else
            key_q <= key_d;
    end

    assign key = key_q;

endmodule

// File: tb/tb_keyboard_spi_rx.sv
// Self-checking bench for keyboard_spi_rx: directed frames from the test plan,
// followed by random frames, compared against a bit-queue reference model.
module tb_keyboard_spi_rx;

    localparam int KW = 8;

    logic          sck = 1'b0;
    logic          rst_n;
    logic          cs_n;
    logic          mosi;
    logic [KW-1:0] key;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: bits of the current frame, plus the expected key.
    bit            q[$];
    logic [KW-1:0] exp_key;

    keyboard_spi_rx #(.KEY_WIDTH(KW)) dut (
        .sck  (sck),
        .rst_n(rst_n),
        .cs_n (cs_n),
        .mosi (mosi),
        .key  (key)
    );

    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Assemble a completed group of bits into a code by arrival order.
    function automatic logic [KW-1:0] pack(input bit b[$]);
        logic [KW-1:0] v = '0;
        for (int i = 0; i < KW; i++) begin
`ifdef KEYBOARD_LSB_FIRST_EN
            v[i] = b[i];
`else
            v[KW-1-i] = b[i];
`endif
        end
        return v;
    endfunction

    // Drive one bit after the falling edge, clock it in, then check after the next falling edge.
    task automatic send_bit(input logic b, input string tag);
        mosi = b;
        cs_n = 1'b0;
        @(posedge sck);
        if (rst_n) begin
            q.push_back(b);
            if (q.size() == KW) begin
                exp_key = pack(q);
                q.delete();
            end
        end
        @(negedge sck);
        #1;
        chk(tag, key, exp_key);
    endtask

    // Send a whole word in the wire order used by the current build.
    task automatic send_word(input logic [KW-1:0] v, input string tag);
        for (int i = 0; i < KW; i++) begin
`ifdef KEYBOARD_LSB_FIRST_EN
            send_bit(v[i], tag);
`else
            send_bit(v[KW-1-i], tag);
`endif
        end
    endtask

    task automatic end_frame(input string tag);
        cs_n = 1'b1;
        q.delete();
        mosi = 1'($urandom);
        @(negedge sck);
        #1;
        chk(tag, key, exp_key);
        @(negedge sck);
        #1;
    endtask

    initial begin
        logic [KW-1:0] aa_exp;
        logic [KW-1:0] rv;
        int            len;
`ifdef KEYBOARD_LSB_FIRST_EN
        aa_exp = 8'h55;
`else
        aa_exp = 8'hAA;
`endif
        exp_key = '0;
        rst_n   = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;

        // Reset with random activity on the inputs
        for (int i = 0; i < 6; i++) begin
            cs_n = 1'($urandom);
            mosi = 1'($urandom);
            @(negedge sck);
            #1;
            chk("reset", key, 8'h00);
        end
        cs_n  = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(negedge sck);
        #1;
        chk("idle_after_reset", key, 8'h00);

        // All-ones frame
        for (int i = 0; i < KW; i++) send_bit(1'b1, "ones");
        chk("ones_val", key, 8'hFF);
        end_frame("ones_hold");
        chk("ones_after_cs", key, 8'hFF);

        // Alternating raw bit pattern 1,0,1,0...
        for (int i = 0; i < KW; i++) send_bit(1'(~i & 1), "alt");
        chk("alt_val", key, aa_exp);
        end_frame("alt_hold");

        // Key release frame
        for (int i = 0; i < KW; i++) send_bit(1'b0, "zero");
        chk("zero_val", key, 8'h00);
        end_frame("zero_hold");

        // Partial frame is discarded, then a full frame proves the counter cleared
        for (int i = 0; i < 5; i++) send_bit(1'b1, "partial");
        end_frame("partial_hold");
        chk("partial_unchanged", key, 8'h00);
        send_word(8'h3C, "w3c");
        chk("w3c_val", key, 8'h3C);
        end_frame("w3c_hold");

        // 16-bit frame carries two codes
        send_word(8'h12, "w12");
        chk("w12_val", key, 8'h12);
        send_word(8'h34, "w34");
        chk("w34_val", key, 8'h34);
        end_frame("w34_hold");

        // Reset pulse in the middle of a frame, with cs_n held low throughout
        for (int i = 0; i < 3; i++) send_bit(1'b1, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", key, 8'h00);
        exp_key = '0;
        q.delete();
        @(negedge sck);
        #1;
        chk("rst_hold", key, 8'h00);
        rst_n = 1'b1;
        send_word(8'h5A, "w5a");
        chk("w5a_val", key, 8'h5A);
        end_frame("w5a_hold");

        // Random frames of random length, including partial and multi-word frames
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 3 * KW);
            for (int i = 0; i < len; i++) begin
                rv = KW'($urandom);
                send_bit(rv[0], "rand");
            end
            end_frame("rand_hold");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
